// File: rtl/reg_file_rd.sv
// Register bank with one write port and two independent registered read ports.
// Reads take one cycle and see a same-edge write (write-first bypass).
module reg_file_rd #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 2,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             rvalid_a_q, rvalid_b_q;
    logic             wr_en;

    assign wr_en = we && !(ZERO_R0 && (waddr == '0));

    // Unrequested ports keep their last data so the output bus does not toggle.
    always_comb begin
        rdata_a_d = rdata_a_q;
        if (re_a) begin
            if (ZERO_R0 && (raddr_a == '0)) begin
                rdata_a_d = '0;
            end else if (we && (raddr_a == waddr)) begin
                rdata_a_d = wdata;
            end else begin
                rdata_a_d = mem_q[raddr_a];
            end
        end
    end

    always_comb begin
        rdata_b_d = rdata_b_q;
        if (re_b) begin
            if (ZERO_R0 && (raddr_b == '0)) begin
                rdata_b_d = '0;
            end else if (we && (raddr_b == waddr)) begin
                rdata_b_d = wdata;
            end else begin
                rdata_b_d = mem_q[raddr_b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= re_a;
            rvalid_b_q <= re_b;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_reg_file_rd.sv
// Directed bench for reg_file_rd: one instance with ZERO_R0=0 and one with ZERO_R0=1,
// both driven by the same stimulus.
module tb_reg_file_rd;

    logic       clk = 1'b0;
    logic       rst, we, re_a, re_b;
    logic [1:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    logic [7:0] rdata_a, rdata_b, zrdata_a, zrdata_b;
    logic       rvalid_a, rvalid_b, zrvalid_a, zrvalid_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_rd #(.WIDTH(8), .DEPTH(4), .AW(2), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
    );

    reg_file_rd #(.WIDTH(8), .DEPTH(4), .AW(2), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(zrdata_a), .rvalid_a(zrvalid_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(zrdata_b), .rvalid_b(zrvalid_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pre [4];
        pre[0] = 8'h10; pre[1] = 8'h20; pre[2] = 8'h30; pre[3] = 8'h40;

        // 1. Reset held with write/read requests active
        rst = 1'b1; we = 1'b1; waddr = 2'd1; wdata = 8'hAA;
        re_a = 1'b1; raddr_a = 2'd1; re_b = 1'b0; raddr_b = 2'd0;
        step(); step();
        chk("rst_rvalid_a", {7'b0, rvalid_a}, 8'h00);
        chk("rst_rdata_a", rdata_a, 8'h00);
        chk("rst_rvalid_b", {7'b0, rvalid_b}, 8'h00);
        chk("rst_rdata_b", rdata_b, 8'h00);
        rst = 1'b0; we = 1'b0;
        step();
        chk("post_rst_rd1", rdata_a, 8'h00);
        chk("post_rst_rvalid_a", {7'b0, rvalid_a}, 8'h01);

        // 2. Write then dual read
        re_a = 1'b0; we = 1'b1; waddr = 2'd2; wdata = 8'h5C;
        step();
        chk("idle_rvalid_a", {7'b0, rvalid_a}, 8'h00);
        we = 1'b0; re_a = 1'b1; raddr_a = 2'd2; re_b = 1'b1; raddr_b = 2'd3;
        step();
        chk("wr_rd_a", rdata_a, 8'h5C);
        chk("wr_rd_b", rdata_b, 8'h00);
        chk("wr_rvalid_a", {7'b0, rvalid_a}, 8'h01);
        chk("wr_rvalid_b", {7'b0, rvalid_b}, 8'h01);

        // Both ports on the same address
        raddr_b = 2'd2;
        step();
        chk("same_addr_a", rdata_a, 8'h5C);
        chk("same_addr_b", rdata_b, 8'h5C);

        // 3. Bypass
        re_a = 1'b0; re_b = 1'b0; we = 1'b1; waddr = 2'd1; wdata = 8'h11;
        step();
        wdata = 8'h77; re_a = 1'b1; raddr_a = 2'd1;
        step();
        chk("bypass_a", rdata_a, 8'h77);
        we = 1'b0;
        step();
        chk("after_bypass_a", rdata_a, 8'h77);

        // 4. Write to address 0 with bypass read, both ZERO_R0 settings
        we = 1'b1; waddr = 2'd0; wdata = 8'hFF; raddr_a = 2'd0;
        step();
        chk("r0_bypass", rdata_a, 8'hFF);
        chk("r0_bypass_z", zrdata_a, 8'h00);
        we = 1'b0;
        step();
        chk("r0_read", rdata_a, 8'hFF);
        chk("r0_read_z", zrdata_a, 8'h00);
        chk("r0_rvalid_z", {7'b0, zrvalid_a}, 8'h01);

        // 5. Preload, stream on port B, then hold
        re_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; waddr = 2'(i); wdata = pre[i];
            step();
        end
        we = 1'b0; re_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            raddr_b = 2'(i);
            step();
            chk($sformatf("stream_b%0d", i), rdata_b, pre[i]);
            chk($sformatf("stream_vb%0d", i), {7'b0, rvalid_b}, 8'h01);
            chk($sformatf("stream_zb%0d", i), zrdata_b, (i == 0) ? 8'h00 : pre[i]);
        end
        re_b = 1'b0;
        step();
        chk("hold_rvalid_b", {7'b0, rvalid_b}, 8'h00);
        chk("hold_rdata_b", rdata_b, 8'h40);
        step();
        chk("hold2_rdata_b", rdata_b, 8'h40);

        // 6. Reset mid-stream with a pending write
        re_a = 1'b1; raddr_a = 2'd1; re_b = 1'b1; raddr_b = 2'd2;
        step();
        chk("pre_rst_a", rdata_a, 8'h20);
        chk("pre_rst_b", rdata_b, 8'h30);
        rst = 1'b1; we = 1'b1; waddr = 2'd3; wdata = 8'h99;
        step();
        chk("mid_rst_rvalid_a", {7'b0, rvalid_a}, 8'h00);
        chk("mid_rst_rvalid_b", {7'b0, rvalid_b}, 8'h00);
        chk("mid_rst_rdata_a", rdata_a, 8'h00);
        chk("mid_rst_rdata_b", rdata_b, 8'h00);
        rst = 1'b0; we = 1'b0; raddr_a = 2'd3; raddr_b = 2'd1;
        step();
        chk("after_rst_addr3", rdata_a, 8'h00);
        chk("after_rst_addr1", rdata_b, 8'h00);
        chk("after_rst_rvalid_a", {7'b0, rvalid_a}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
